leaf_mem_responder: RTL and testbench

Leaf memory that services the main controller's leaf port. It holds up to NUM_LEAVES leaves of LEAF_SIZE patches each. A write port fills the memory from the tree-build/load path. The read port answers the controller's leaf_mem_ren/leaf_mem_radr requests with fixed-latency data and a valid strobe, which feed the L2 kernels. A per-entry valid bitmap and a load counter report fill status, so the controller can tell when the memory is ready to start a search.

---
 rtl/leaf_mem_if.sv | 31 +++
 rtl/leaf_mem_responder.sv | 142 ++++++++++++++
 tb/tb_leaf_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_mem_if.sv
// Leaf memory port bundle: write/fill path, controller read path and fill status.
// The master drives requests and write data; the slave returns read data and status.
interface leaf_mem_if #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
);
  logic                                  clear;
  logic                                  leaf_mem_wen;
  logic [ADDR_WIDTH-1:0]                 leaf_mem_wadr;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] leaf_mem_wdata [LEAF_SIZE];
  logic                                  leaf_mem_ren;
  logic [ADDR_WIDTH-1:0]                 leaf_mem_radr;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] leaf_rdata [LEAF_SIZE];
  logic                                  leaf_rvalid;
  logic                                  leaf_rmiss;
  logic [ADDR_WIDTH:0]                   leaves_loaded;
  logic                                  all_loaded;

  modport master (
    output clear, leaf_mem_wen, leaf_mem_wadr, leaf_mem_wdata, leaf_mem_ren, leaf_mem_radr,
    input  leaf_rdata, leaf_rvalid, leaf_rmiss, leaves_loaded, all_loaded
  );

  modport slave (
    input  clear, leaf_mem_wen, leaf_mem_wadr, leaf_mem_wdata, leaf_mem_ren, leaf_mem_radr,
    output leaf_rdata, leaf_rvalid, leaf_rmiss, leaves_loaded, all_loaded
  );
endinterface

// File: rtl/leaf_mem_responder.sv
// Leaf memory for the search controller: write-first fill port, fixed-latency read port
// with miss flag, and a valid bitmap plus distinct-entry load counter.
module leaf_mem_responder #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
  parameter int OUT_REG    = 0
) (
  input logic        clk,
  input logic        rst_n,
  leaf_mem_if.slave  bus
);
  localparam int ENTRY_W = PATCH_SIZE * DATA_WIDTH;
  localparam int WORD_W  = LEAF_SIZE * ENTRY_W;
  localparam logic [ADDR_WIDTH:0] NUM_LEAVES_W = (ADDR_WIDTH+1)'(NUM_LEAVES);

  logic [WORD_W-1:0]     r_mem [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] r_valid;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_all;

  logic                  r_s1_vld;
  logic                  r_s1_miss;
  logic [WORD_W-1:0]     r_s1_data;

  logic [WORD_W-1:0]     w_wdata_flat;
  logic [WORD_W-1:0]     w_rd_word;
  logic [WORD_W-1:0]     w_out_data;
  logic                  w_out_vld;
  logic                  w_out_miss;
  logic                  w_wr_ok;
  logic                  w_rd_in;
  logic                  w_bypass;
  logic                  w_rd_hit;
  logic [NUM_LEAVES-1:0] w_valid_next;
  logic [ADDR_WIDTH:0]   w_count_next;

  generate
    for (genvar gi = 0; gi < LEAF_SIZE; gi++) begin : g_pack
      assign w_wdata_flat[gi*ENTRY_W +: ENTRY_W] = bus.leaf_mem_wdata[gi];
      assign bus.leaf_rdata[gi]                  = w_out_data[gi*ENTRY_W +: ENTRY_W];
    end
  endgenerate

  assign w_wr_ok  = bus.leaf_mem_wen && ({1'b0, bus.leaf_mem_wadr} < NUM_LEAVES_W);
  assign w_rd_in  = {1'b0, bus.leaf_mem_radr} < NUM_LEAVES_W;
  assign w_bypass = w_wr_ok && (bus.leaf_mem_wadr == bus.leaf_mem_radr);
  assign w_rd_hit = w_rd_in && (r_valid[bus.leaf_mem_radr] || w_bypass);

  // Clear first, then the same-cycle write lands on the cleared bitmap.
  always_comb begin
    w_valid_next = r_valid;
    w_count_next = r_count;
    if (bus.clear) begin
      w_valid_next = '0;
      w_count_next = '0;
    end
    if (w_wr_ok) begin
      if (!w_valid_next[bus.leaf_mem_wadr]) begin
        w_count_next = w_count_next + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      w_valid_next[bus.leaf_mem_wadr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      r_all   <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
      r_all   <= (w_count_next == NUM_LEAVES_W);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.leaf_mem_wadr] <= w_wdata_flat;
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_hit) begin
      w_rd_word = w_bypass ? w_wdata_flat : r_mem[bus.leaf_mem_radr];
    end
  end

  // Data only moves on a request so the output holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_miss <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld  <= bus.leaf_mem_ren;
      r_s1_miss <= bus.leaf_mem_ren && !w_rd_hit;
      if (bus.leaf_mem_ren) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_s2_vld;
      logic              r_s2_miss;
      logic [WORD_W-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_vld  <= 1'b0;
          r_s2_miss <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld  <= r_s1_vld;
          r_s2_miss <= r_s1_miss;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign w_out_vld  = r_s2_vld;
      assign w_out_miss = r_s2_miss;
      assign w_out_data = r_s2_data;
    end else begin : g_no_out_reg
      assign w_out_vld  = r_s1_vld;
      assign w_out_miss = r_s1_miss;
      assign w_out_data = r_s1_data;
    end
  endgenerate

  assign bus.leaf_rvalid   = w_out_vld;
  assign bus.leaf_rmiss    = w_out_miss;
  assign bus.leaves_loaded = r_count;
  assign bus.all_loaded    = r_all;
endmodule

// File: tb/tb_leaf_mem_responder.sv
// Bench for leaf_mem_responder: two instances (64 leaves / latency 1, 48 leaves / latency 2)
// share one stimulus stream; a reference model feeds per-instance read scoreboards.
module tb_leaf_mem_responder;
  localparam int DW = 11;
  localparam int LS = 8;
  localparam int PS = 5;
  localparam int EW = PS * DW;
  localparam int FW = LS * EW;
  localparam int AW = 6;
  localparam int N0 = 64;
  localparam int N1 = 48;

  typedef struct {
    int              due;
    logic            miss;
    logic [FW-1:0]   data;
  } exp_t;

  typedef struct {
    logic clr;
    logic wen;
    int   wadr;
    int   seed;
    logic ren;
    int   radr;
    int   cnt0;
    int   cnt1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic                  t_clear, t_wen, t_ren;
  logic [AW-1:0]         t_wadr, t_radr;
  logic [PS-1:0][DW-1:0] t_wdata [LS];

  exp_t          q0[$];
  exp_t          q1[$];
  logic [FW-1:0] m_mem [2][64];
  bit   [63:0]   m_vld [2];
  logic [FW-1:0] last [2];
  logic [FW-1:0] o0, o1;
  vec_t          tbl [29];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  leaf_mem_if #(.DATA_WIDTH(DW), .LEAF_SIZE(LS), .PATCH_SIZE(PS), .NUM_LEAVES(N0)) bus0 ();
  leaf_mem_if #(.DATA_WIDTH(DW), .LEAF_SIZE(LS), .PATCH_SIZE(PS), .NUM_LEAVES(N1)) bus1 ();

  assign bus0.clear          = t_clear;
  assign bus0.leaf_mem_wen   = t_wen;
  assign bus0.leaf_mem_wadr  = t_wadr;
  assign bus0.leaf_mem_wdata = t_wdata;
  assign bus0.leaf_mem_ren   = t_ren;
  assign bus0.leaf_mem_radr  = t_radr;
  assign bus1.clear          = t_clear;
  assign bus1.leaf_mem_wen   = t_wen;
  assign bus1.leaf_mem_wadr  = t_wadr;
  assign bus1.leaf_mem_wdata = t_wdata;
  assign bus1.leaf_mem_ren   = t_ren;
  assign bus1.leaf_mem_radr  = t_radr;

  leaf_mem_responder #(.DATA_WIDTH(DW), .LEAF_SIZE(LS), .PATCH_SIZE(PS),
                       .NUM_LEAVES(N0), .OUT_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  leaf_mem_responder #(.DATA_WIDTH(DW), .LEAF_SIZE(LS), .PATCH_SIZE(PS),
                       .NUM_LEAVES(N1), .OUT_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always_comb begin
    o0 = '0;
    o1 = '0;
    for (int i = 0; i < LS; i++) begin
      o0[i*EW +: EW] = bus0.leaf_rdata[i];
      o1[i*EW +: EW] = bus1.leaf_rdata[i];
    end
  end

  function automatic logic [FW-1:0] make_word(input int seed);
    logic [FW-1:0] w;
    w = '0;
    for (int i = 0; i < LS; i++)
      for (int p = 0; p < PS; p++)
        w[i*EW + p*DW +: DW] = DW'(seed * 8 + i + p);
    return w;
  endfunction

  task automatic chk(input string nm, input int d, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d act=%h exp=%h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic pop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon(input int d, input logic v, input logic m, input logic [FW-1:0] dat);
    exp_t e;
    bit   have;
    bit   due;
    have = 1'b0;
    if (d == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (have && e.due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rvalid_missing dut%0d cyc=%0d act=0 exp=1 due=%0d", d, cyc, e.due);
      pop(d);
      have = 1'b0;
    end
    due = have && (e.due == cyc);
    if (v || due) begin
      chk("rvalid", d, FW'(v), FW'(due));
      if (v && due) begin
        chk("rmiss", d, FW'(m), FW'(e.miss));
        chk("rdata", d, dat, e.data);
        $display("dut%0d cyc=%0d read miss=%0b", d, cyc, m);
        last[d] = e.data;
        pop(d);
      end
    end else begin
      chk("rmiss_idle", d, FW'(m), '0);
      chk("rdata_hold", d, dat, last[d]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.leaf_rvalid, bus0.leaf_rmiss, o0);
    mon(1, bus1.leaf_rvalid, bus1.leaf_rmiss, o1);
  end

  // Drive one cycle of stimulus, update the model, queue expected reads, check status after the edge.
  task automatic step(input logic clr, input logic wen, input int wadr, input int seed,
                      input logic ren, input int radr);
    logic [FW-1:0] wword;
    exp_t          e;
    int            n, cnt;
    bit            inr_r, inr_w, byp, hit;
    wword   = make_word(seed);
    t_clear = clr;
    t_wen   = wen;
    t_wadr  = AW'(wadr);
    t_ren   = ren;
    t_radr  = AW'(radr);
    for (int i = 0; i < LS; i++)
      for (int p = 0; p < PS; p++)
        t_wdata[i][p] = DW'(seed * 8 + i + p);
    for (int d = 0; d < 2; d++) begin
      n     = (d == 0) ? N0 : N1;
      inr_r = radr < n;
      inr_w = wen && (wadr < n);
      byp   = inr_w && (wadr == radr);
      hit   = inr_r && (m_vld[d][radr] || byp);
      if (ren) begin
        e.due  = cyc + ((d == 0) ? 1 : 2);
        e.miss = !hit;
        e.data = hit ? (byp ? wword : m_mem[d][radr]) : '0;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      if (clr) m_vld[d] = '0;
      if (inr_w) begin
        m_mem[d][wadr] = wword;
        m_vld[d][wadr] = 1'b1;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n   = (d == 0) ? N0 : N1;
      cnt = $countones(m_vld[d]);
      chk("leaves_loaded", d, FW'((d == 0) ? bus0.leaves_loaded : bus1.leaves_loaded), FW'(cnt));
      chk("all_loaded", d, FW'((d == 0) ? bus0.all_loaded : bus1.all_loaded), FW'(cnt == n));
    end
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, 0, FW'(bus0.leaf_rvalid), '0);
    chk({tag, "_rvalid"}, 1, FW'(bus1.leaf_rvalid), '0);
    chk({tag, "_rmiss"}, 0, FW'(bus0.leaf_rmiss), '0);
    chk({tag, "_rmiss"}, 1, FW'(bus1.leaf_rmiss), '0);
    chk({tag, "_rdata"}, 0, o0, '0);
    chk({tag, "_rdata"}, 1, o1, '0);
    chk({tag, "_loaded"}, 0, FW'(bus0.leaves_loaded), '0);
    chk({tag, "_loaded"}, 1, FW'(bus1.leaves_loaded), '0);
    chk({tag, "_all"}, 0, FW'(bus0.all_loaded), '0);
    chk({tag, "_all"}, 1, FW'(bus1.all_loaded), '0);
  endtask

  initial begin
    // clr, wen, wadr, seed, ren, radr, expected count (64-leaf), expected count (48-leaf)
    tbl[0]  = '{1'b0, 1'b0,  0,   0, 1'b1,  5, 0, 0};
    tbl[1]  = '{1'b0, 1'b1,  5,   5, 1'b0,  0, 1, 1};
    tbl[2]  = '{1'b0, 1'b0,  0,   0, 1'b1,  5, 1, 1};
    tbl[3]  = '{1'b0, 1'b1,  9,   9, 1'b0,  0, 2, 2};
    tbl[4]  = '{1'b0, 1'b1,  9, 200, 1'b1,  9, 2, 2};
    tbl[5]  = '{1'b0, 1'b0,  0,   0, 1'b1,  9, 2, 2};
    tbl[6]  = '{1'b0, 1'b1, 50,  50, 1'b0,  0, 3, 2};
    tbl[7]  = '{1'b0, 1'b0,  0,   0, 1'b1, 50, 3, 2};
    tbl[8]  = '{1'b1, 1'b0,  0,   0, 1'b0,  0, 0, 0};
    for (int k = 0; k < 10; k++) tbl[9 + k] = '{1'b0, 1'b1, k, k + 10, 1'b0, 0, k + 1, k + 1};
    tbl[19] = '{1'b1, 1'b1,  3,  77, 1'b0,  0, 1, 1};
    tbl[20] = '{1'b0, 1'b0,  0,   0, 1'b1,  0, 1, 1};
    tbl[21] = '{1'b0, 1'b0,  0,   0, 1'b1,  3, 1, 1};
    tbl[22] = '{1'b1, 1'b1, 50,  60, 1'b0,  0, 1, 0};
    tbl[23] = '{1'b1, 1'b0,  0,   0, 1'b0,  0, 0, 0};
    tbl[24] = '{1'b0, 1'b1, 47,  47, 1'b0,  0, 1, 1};
    tbl[25] = '{1'b0, 1'b0,  0,   0, 1'b1, 47, 1, 1};
    tbl[26] = '{1'b0, 1'b1, 48,  48, 1'b0,  0, 2, 1};
    tbl[27] = '{1'b0, 1'b0,  0,   0, 1'b1, 48, 2, 1};
    tbl[28] = '{1'b1, 1'b0,  0,   0, 1'b0,  0, 0, 0};

    t_clear = 1'b0; t_wen = 1'b0; t_ren = 1'b0; t_wadr = '0; t_radr = '0;
    for (int i = 0; i < LS; i++) t_wdata[i] = '0;
    m_vld[0] = '0; m_vld[1] = '0;
    last[0] = '0; last[1] = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int r = 0; r < 29; r++) begin
      step(tbl[r].clr, tbl[r].wen, tbl[r].wadr, tbl[r].seed, tbl[r].ren, tbl[r].radr);
      chk("tbl_loaded", 0, FW'(bus0.leaves_loaded), FW'(tbl[r].cnt0));
      chk("tbl_loaded", 1, FW'(bus1.leaves_loaded), FW'(tbl[r].cnt1));
      $display("vector %0d loaded=%0d/%0d", r, bus0.leaves_loaded, bus1.leaves_loaded);
    end
    idle(3);

    // Fill every leaf, then stream back-to-back reads of all of them.
    for (int a = 0; a < 64; a++) step(1'b0, 1'b1, a, a, 1'b0, 0);
    chk("full_loaded", 0, FW'(bus0.leaves_loaded), FW'(64));
    chk("full_all", 0, FW'(bus0.all_loaded), FW'(1));
    chk("full_loaded", 1, FW'(bus1.leaves_loaded), FW'(48));
    chk("full_all", 1, FW'(bus1.all_loaded), FW'(1));
    for (int a = 0; a < 64; a++) step(1'b0, 1'b0, 0, 0, 1'b1, a);
    idle(3);

    for (int k = 0; k < 300; k++) begin
      int   wa, ra;
      logic rn, cl;
      wa = int'($urandom_range(0, 63));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 63));
      rn = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 31) == 0) && !rn;
      step(cl, 1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 255)), rn, ra);
    end
    idle(3);

    // Leaf 2 is valid; read it, then reset while the latency-2 instance still has it in flight.
    step(1'b0, 1'b1, 2, 33, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b1, 2);
    t_ren = 1'b0;
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    m_vld[0] = '0; m_vld[1] = '0;
    last[0] = '0; last[1] = '0;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("in_reset");
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    idle(4);
    chk_reset_outputs("post_reset");
    step(1'b0, 1'b0, 0, 0, 1'b1, 2);
    idle(4);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d/%0d exp=0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
